wb_decoder_2: RTL

Single-master, two-slave Wishbone address decoder placed directly downstream of the two-master arbiter. It accepts the arbiter's granted bus and routes each transfer to one of two slaves by base/mask match. Unmapped addresses and stalled slaves terminate with a bus error. The slave selection is registered and held for the whole transfer.

---
 rtl/wb_decoder_2_pkg.sv | 13 +
 rtl/wb_decoder_2_if.sv | 28 ++
 rtl/wb_decoder_2_watchdog.sv | 27 ++
 rtl/wb_decoder_2.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/wb_decoder_2_pkg.sv
// Shared types for the two-slave Wishbone decoder.
package wb_pkg;

    localparam int unsigned WB_DEC_NSLAVES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2,
        ERR   = 2'd3
    } wb_dec_state_t;

endpackage

// File: rtl/wb_decoder_2_if.sv
// Wishbone point-to-point bundle. Modport 'master' is the view of a port that faces a
// bus master (request in, response out); 'slave' is the view of a port facing a slave.
interface wb_intf #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;   // master to slave
    logic [DATA_WIDTH-1:0]   dat_r;   // slave to master
    logic                    we;
    logic [SELECT_WIDTH-1:0] sel;
    logic                    stb;
    logic                    cyc;
    logic                    ack;
    logic                    err;
    logic                    rty;

    modport master (
        input  adr, dat_w, we, sel, stb, cyc,
        output dat_r, ack, err, rty
    );

    modport slave (
        output adr, dat_w, we, sel, stb, cyc,
        input  dat_r, ack, err, rty
    );
endinterface

// File: rtl/wb_decoder_2_watchdog.sv
// Busy-cycle watchdog for the decoder; only built when WB_DECODER_TIMEOUT_EN is defined.
`ifdef WB_DECODER_TIMEOUT_EN
module wb_watchdog #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expired
);
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;

    // Count unterminated busy cycles; held at zero whenever no transfer is active.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = (r_cnt == CW'(TIMEOUT - 1));
endmodule
`endif

// File: rtl/wb_decoder_2.sv
// Two-slave Wishbone address decoder with registered slave selection.
// Optional busy watchdog enabled by defining WB_DECODER_TIMEOUT_EN.
module wb_decoder_2
    import wb_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           SELECT_WIDTH = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] S0_BASE      = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] S0_MASK      = 32'hF000_0000,
    parameter logic [ADDR_WIDTH-1:0] S1_BASE      = 32'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] S1_MASK      = 32'hF000_0000,
    parameter int unsigned           TIMEOUT      = 256
) (
    input  logic    clk,
    input  logic    rst_n,
    wb_intf.master  wbm,
    wb_intf.slave   wbs0,
    wb_intf.slave   wbs1
);
    localparam logic [DATA_WIDTH-1:0]   DAT_ZERO = '0;
    localparam logic [SELECT_WIDTH-1:0] SEL_ZERO = '0;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("wb_decoder_2: TIMEOUT must be at least 2");
    end

    wb_dec_state_t               r_state;
    wb_dec_state_t               w_state_nxt;
    logic [WB_DEC_NSLAVES-1:0]   w_hit;
    logic                        w_req;
    logic                        w_term0;
    logic                        w_term1;
    logic                        w_expired;

    assign w_hit[0] = ((wbm.adr & S0_MASK) == S0_BASE);
    assign w_hit[1] = ((wbm.adr & S1_MASK) == S1_BASE);
    assign w_req    = wbm.cyc & wbm.stb;
    assign w_term0  = wbs0.ack | wbs0.err | wbs0.rty;
    assign w_term1  = wbs1.ack | wbs1.err | wbs1.rty;

`ifdef WB_DECODER_TIMEOUT_EN
    logic w_busy;
    logic w_run;

    assign w_busy = (r_state == BUSY0) || (r_state == BUSY1);
    assign w_run  = ((r_state == BUSY0) && !w_term0) || ((r_state == BUSY1) && !w_term1);

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!w_busy),
        .run     (w_run),
        .expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: decode on request, leave busy on termination, abort or watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_hit[0])      w_state_nxt = BUSY0;
                    else if (w_hit[1]) w_state_nxt = BUSY1;
                    else               w_state_nxt = ERR;
                end
            end
            BUSY0: begin
                if (w_term0 || !wbm.cyc) w_state_nxt = IDLE;
                else if (w_expired)      w_state_nxt = ERR;
            end
            BUSY1: begin
                if (w_term1 || !wbm.cyc) w_state_nxt = IDLE;
                else if (w_expired)      w_state_nxt = ERR;
            end
            ERR: w_state_nxt = IDLE;
        endcase
    end

    // Bus routing: only the selected slave is driven; responses come from it alone.
    always_comb begin
        wbm.dat_r  = DAT_ZERO;
        wbm.ack    = 1'b0;
        wbm.err    = 1'b0;
        wbm.rty    = 1'b0;
        wbs0.adr   = '0;
        wbs0.dat_w = DAT_ZERO;
        wbs0.we    = 1'b0;
        wbs0.sel   = SEL_ZERO;
        wbs0.stb   = 1'b0;
        wbs0.cyc   = 1'b0;
        wbs1.adr   = '0;
        wbs1.dat_w = DAT_ZERO;
        wbs1.we    = 1'b0;
        wbs1.sel   = SEL_ZERO;
        wbs1.stb   = 1'b0;
        wbs1.cyc   = 1'b0;
        unique case (r_state)
            IDLE: ;
            BUSY0: begin
                wbs0.adr   = wbm.adr;
                wbs0.dat_w = wbm.dat_w;
                wbs0.we    = wbm.we;
                wbs0.sel   = wbm.sel;
                wbs0.stb   = wbm.stb;
                wbs0.cyc   = wbm.cyc;
                wbm.dat_r  = wbs0.dat_r;
                wbm.ack    = wbs0.ack;
                wbm.err    = wbs0.err;
                wbm.rty    = wbs0.rty;
            end
            BUSY1: begin
                wbs1.adr   = wbm.adr;
                wbs1.dat_w = wbm.dat_w;
                wbs1.we    = wbm.we;
                wbs1.sel   = wbm.sel;
                wbs1.stb   = wbm.stb;
                wbs1.cyc   = wbm.cyc;
                wbm.dat_r  = wbs1.dat_r;
                wbm.ack    = wbs1.ack;
                wbm.err    = wbs1.err;
                wbm.rty    = wbs1.rty;
            end
            ERR: wbm.err = 1'b1;
        endcase
    end
endmodule
